duel_game_ctrl: RTL and testbench
=================================

// Module: duel_game_ctrl
// PURPOSE
// Game-flow controller for the two-player reaction duel. Sits directly upstream of the VGA display top.
// Turns debounced button pulses into the state, score0, score1 and cnt0 values that the pixel generator renders.
// Runs a countdown, then a GO window, then a point-display hold. Ends the match at WIN_SCORE.
// PARAMETERS
// TICK_DIV    100_000_000  clk cycles per game tick (1 s at 100 MHz); >=2
// COUNT_FROM  3            countdown start value shown on cnt0; 1..9
// GO_TIMEOUT  5            ticks in GO with no press before round is void; >=1
// HOLD_TICKS  2            ticks the POINT result is held on screen; >=1
// WIN_SCORE   5            points needed to win; 1..9 (single-digit display)
// PORTS
// clk        in   1  system clock (100 MHz)
// rst        in   1  synchronous, active-high reset
// start      in   1  one-cycle pulse, debounced start/restart button
// btn0       in   1  one-cycle pulse, player 0 button
// btn1       in   1  one-cycle pulse, player 1 button
// state      out  4  0=IDLE 1=COUNT 2=GO 3=POINT 4=WIN0 5=WIN1; 6..15 unused
// score0     out  4  player 0 score, 0..WIN_SCORE
// score1     out  4  player 1 score, 0..WIN_SCORE
// cnt0       out  4  countdown digit; 0 outside COUNT except IDLE
// last_pt    out  2  last round result: 00 none/void/draw, 01 p0, 10 p1
// BEHAVIOUR
// - All outputs are registered. Reset values: state=IDLE, score0=score1=0, cnt0=COUNT_FROM, last_pt=00, tick_cnt=0, aux_cnt=0.
// - rst overrides every other input on the same edge, including mid-round.
// - Tick: tick_cnt counts 0..TICK_DIV-1 and wraps. tick=1 in the cycle tick_cnt==TICK_DIV-1. tick_cnt and aux_cnt clear on every state entry.
// - IDLE: start -> COUNT; cnt0=COUNT_FROM; scores 0. btn0/btn1 ignored.
// - COUNT: on tick, if cnt0>1 then cnt0-1; if cnt0==1 then cnt0=0 and go to GO.
//   COUNT_FROM ticks = COUNT_FROM*TICK_DIV cycles from COUNT entry to GO entry.
// - COUNT foul, btn0 only: score1+1, last_pt=10 -> POINT.
// - COUNT foul, btn1 only: score0+1, last_pt=01 -> POINT.
// - COUNT foul, btn0 and btn1 in the same cycle: no score, last_pt=00 -> POINT.
// - A foul takes priority over a tick in the same cycle. cnt0 freezes at its current value, then is cleared to 0 on POINT entry.
// - GO: btn0 only -> score0+1, last_pt=01. btn1 only -> score1+1, last_pt=10. Both in the same cycle -> no score, last_pt=00.
//   Each of these moves to POINT on the same edge.
// - GO timeout: aux_cnt counts ticks. At the GO_TIMEOUT-th tick with no press, last_pt=00 -> POINT. A press in that same cycle wins over the timeout.
// - POINT: buttons and start ignored. After HOLD_TICKS ticks, checks in priority order:
//   score0==WIN_SCORE -> WIN0; else score1==WIN_SCORE -> WIN1; else COUNT with cnt0=COUNT_FROM.
// - WIN0/WIN1: scores frozen, buttons ignored. start -> IDLE with score0=score1=0, cnt0=COUNT_FROM, last_pt=00.
// - start is ignored in COUNT, GO and POINT.
// - Scores never exceed WIN_SCORE, because the match ends first. Score arithmetic is 4-bit unsigned with no wrap.
// - Unused state codes 6..15 recover to IDLE on the next edge with reset values.
// TESTING (TICK_DIV=4, COUNT_FROM=3, GO_TIMEOUT=5, HOLD_TICKS=2, WIN_SCORE=3)
// 1 Start pulse from IDLE:
//   -> state=1, cnt0=3. cnt0 reads 2 after 4 cycles and 1 after 8. At 12 cycles state=2 and cnt0=0.
// 2 btn1 in GO:
//   -> next edge state=3, score1=1, last_pt=10. After 8 cycles state=1 and cnt0=3.
// 3 btn0 at cnt0=2 (foul), then btn0+btn1 in the same GO cycle:
//   -> first round score1=1, last_pt=10. Second round scores unchanged, last_pt=00.
// 4 No press in GO for 20 cycles:
//   -> state=3, last_pt=00, scores unchanged.
// 5 p0 wins 3 rounds:
//   -> after the 3rd POINT hold, state=4 and score0=3. Buttons have no effect.
//   -> start gives state=0, score0=0, score1=0, cnt0=3.
// 6 Reset and corner cases:
//   - rst asserted mid-COUNT at cnt0=1 -> next edge all reset values.
//   - start during GO -> ignored.
//   - foul coinciding with a tick -> foul wins.

Source files
------------

// File: rtl/duel_game_ctrl.sv
// Game-flow controller for the two-player reaction duel: countdown, GO window, point hold, match win.
// All outputs registered; one-cycle button/start pulses take effect on the next clk edge.
module duel_game_ctrl #(
    parameter int unsigned TICK_DIV   = 100_000_000,
    parameter int unsigned COUNT_FROM = 3,
    parameter int unsigned GO_TIMEOUT = 5,
    parameter int unsigned HOLD_TICKS = 2,
    parameter int unsigned WIN_SCORE  = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       btn0,
    input  logic       btn1,
    output logic [3:0] state,
    output logic [3:0] score0,
    output logic [3:0] score1,
    output logic [3:0] cnt0,
    output logic [1:0] last_pt
);

    localparam int unsigned TICK_W  = $clog2(TICK_DIV);
    localparam int unsigned AUX_MAX = (GO_TIMEOUT > HOLD_TICKS) ? GO_TIMEOUT : HOLD_TICKS;
    localparam int unsigned AUX_W   = $clog2(AUX_MAX + 1);

    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
    localparam logic [AUX_W-1:0]  GO_LAST   = AUX_W'(GO_TIMEOUT - 1);
    localparam logic [AUX_W-1:0]  HOLD_LAST = AUX_W'(HOLD_TICKS - 1);
    localparam logic [3:0]        CNT_INIT  = 4'(COUNT_FROM);
    localparam logic [3:0]        WIN       = 4'(WIN_SCORE);

    typedef enum logic [3:0] {
        S_IDLE  = 4'd0,
        S_COUNT = 4'd1,
        S_GO    = 4'd2,
        S_POINT = 4'd3,
        S_WIN0  = 4'd4,
        S_WIN1  = 4'd5
    } state_t;

    state_t            state_q, state_d;
    logic [3:0]        score0_q, score0_d, score1_q, score1_d, cnt0_q, cnt0_d;
    logic [1:0]        last_pt_q, last_pt_d;
    logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
    logic [AUX_W-1:0]  aux_cnt_q, aux_cnt_d;
    logic              tick;

    assign tick = (tick_cnt_q == TICK_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            score0_q   <= 4'd0;
            score1_q   <= 4'd0;
            cnt0_q     <= CNT_INIT;
            last_pt_q  <= 2'b00;
            tick_cnt_q <= '0;
            aux_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            score0_q   <= score0_d;
            score1_q   <= score1_d;
            cnt0_q     <= cnt0_d;
            last_pt_q  <= last_pt_d;
            tick_cnt_q <= tick_cnt_d;
            aux_cnt_q  <= aux_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        score0_d   = score0_q;
        score1_d   = score1_q;
        cnt0_d     = cnt0_q;
        last_pt_d  = last_pt_q;
        tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
        aux_cnt_d  = aux_cnt_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d  = S_COUNT;
                    cnt0_d   = CNT_INIT;
                    score0_d = 4'd0;
                    score1_d = 4'd0;
                end
            end
            S_COUNT: begin
                // A press during the countdown is a foul and beats a same-cycle tick.
                if (btn0 || btn1) begin
                    state_d = S_POINT;
                    cnt0_d  = 4'd0;
                    if (btn0 && btn1) begin
                        last_pt_d = 2'b00;
                    end else if (btn0) begin
                        score1_d  = score1_q + 4'd1;
                        last_pt_d = 2'b10;
                    end else begin
                        score0_d  = score0_q + 4'd1;
                        last_pt_d = 2'b01;
                    end
                end else if (tick) begin
                    cnt0_d = cnt0_q - 4'd1;
                    if (cnt0_q <= 4'd1) begin
                        cnt0_d  = 4'd0;
                        state_d = S_GO;
                    end
                end
            end
            S_GO: begin
                if (btn0 || btn1) begin
                    state_d = S_POINT;
                    if (btn0 && btn1) begin
                        last_pt_d = 2'b00;
                    end else if (btn0) begin
                        score0_d  = score0_q + 4'd1;
                        last_pt_d = 2'b01;
                    end else begin
                        score1_d  = score1_q + 4'd1;
                        last_pt_d = 2'b10;
                    end
                end else if (tick) begin
                    aux_cnt_d = aux_cnt_q + 1'b1;
                    if (aux_cnt_q == GO_LAST) begin
                        state_d   = S_POINT;
                        last_pt_d = 2'b00;
                    end
                end
            end
            S_POINT: begin
                if (tick) begin
                    aux_cnt_d = aux_cnt_q + 1'b1;
                    if (aux_cnt_q == HOLD_LAST) begin
                        if (score0_q == WIN) begin
                            state_d = S_WIN0;
                        end else if (score1_q == WIN) begin
                            state_d = S_WIN1;
                        end else begin
                            state_d = S_COUNT;
                            cnt0_d  = CNT_INIT;
                        end
                    end
                end
            end
            S_WIN0, S_WIN1: begin
                if (start) begin
                    state_d   = S_IDLE;
                    score0_d  = 4'd0;
                    score1_d  = 4'd0;
                    cnt0_d    = CNT_INIT;
                    last_pt_d = 2'b00;
                end
            end
            default: begin
                // Illegal encodings fall back to the reset picture.
                state_d   = S_IDLE;
                score0_d  = 4'd0;
                score1_d  = 4'd0;
                cnt0_d    = CNT_INIT;
                last_pt_d = 2'b00;
            end
        endcase

        if (state_d != state_q) begin
            tick_cnt_d = '0;
            aux_cnt_d  = '0;
        end
    end

    assign state   = state_q;
    assign score0  = score0_q;
    assign score1  = score1_q;
    assign cnt0    = cnt0_q;
    assign last_pt = last_pt_q;

endmodule

// File: tb/tb_duel_game_ctrl.sv
// Directed bench for duel_game_ctrl with a fast tick (TICK_DIV=4) and WIN_SCORE=3.
module tb_duel_game_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       btn0 = 1'b0;
    logic       btn1 = 1'b0;
    logic [3:0] state, score0, score1, cnt0;
    logic [1:0] last_pt;

    int n_checks = 0;
    int n_errors = 0;

    duel_game_ctrl #(
        .TICK_DIV  (4),
        .COUNT_FROM(3),
        .GO_TIMEOUT(5),
        .HOLD_TICKS(2),
        .WIN_SCORE (3)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .btn0   (btn0),
        .btn1   (btn1),
        .state  (state),
        .score0 (score0),
        .score1 (score1),
        .cnt0   (cnt0),
        .last_pt(last_pt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance n rising edges and settle 1 time unit past the last one.
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
        end
        #1;
    endtask

    task automatic pulse(input logic s, input logic b0, input logic b1);
        start = s;
        btn0  = b0;
        btn1  = b1;
        step(1);
        start = 1'b0;
        btn0  = 1'b0;
        btn1  = 1'b0;
    endtask

    task automatic expect_all(input string tag, input logic [3:0] st, input logic [3:0] s0,
                              input logic [3:0] s1, input logic [3:0] c0, input logic [1:0] lp);
        check({tag, ".state"},   8'(state),   8'(st));
        check({tag, ".score0"},  8'(score0),  8'(s0));
        check({tag, ".score1"},  8'(score1),  8'(s1));
        check({tag, ".cnt0"},    8'(cnt0),    8'(c0));
        check({tag, ".last_pt"}, 8'(last_pt), 8'(lp));
    endtask

    initial begin
        step(2);
        rst = 1'b0;
        expect_all("reset", 4'd0, 4'd0, 4'd0, 4'd3, 2'b00);

        // Buttons in IDLE do nothing.
        pulse(1'b0, 1'b1, 1'b1);
        expect_all("idle_btn", 4'd0, 4'd0, 4'd0, 4'd3, 2'b00);

        // 1: countdown timing
        pulse(1'b1, 1'b0, 1'b0);
        expect_all("count_entry", 4'd1, 4'd0, 4'd0, 4'd3, 2'b00);
        step(3);
        check("cnt0_at3", 8'(cnt0), 8'd3);
        step(1);
        check("cnt0_at4", 8'(cnt0), 8'd2);
        step(4);
        check("cnt0_at8", 8'(cnt0), 8'd1);
        step(3);
        check("state_at11", 8'(state), 8'd1);
        step(1);
        expect_all("go_entry", 4'd2, 4'd0, 4'd0, 4'd0, 2'b00);

        // start during GO is ignored
        pulse(1'b1, 1'b0, 1'b0);
        check("go_start_ign", 8'(state), 8'd2);

        // 2: btn1 wins in GO, then hold of 8 cycles
        pulse(1'b0, 1'b0, 1'b1);
        expect_all("go_btn1", 4'd3, 4'd0, 4'd1, 4'd0, 2'b10);
        pulse(1'b1, 1'b1, 1'b0);
        expect_all("point_ign", 4'd3, 4'd0, 4'd1, 4'd0, 2'b10);
        step(6);
        check("hold_at7", 8'(state), 8'd3);
        step(1);
        expect_all("hold_done", 4'd1, 4'd0, 4'd1, 4'd3, 2'b10);

        // 3: foul by p0 at cnt0=2
        step(4);
        check("foul_cnt0", 8'(cnt0), 8'd2);
        pulse(1'b0, 1'b1, 1'b0);
        expect_all("foul_p0", 4'd3, 4'd0, 4'd2, 4'd0, 2'b10);
        step(8);
        check("foul_back", 8'(state), 8'd1);
        step(12);
        check("go2_entry", 8'(state), 8'd2);
        pulse(1'b0, 1'b1, 1'b1);
        expect_all("go_draw", 4'd3, 4'd0, 4'd2, 4'd0, 2'b00);
        step(8);
        check("draw_back", 8'(state), 8'd1);

        // Foul coinciding with the first countdown tick: foul must win
        step(3);
        pulse(1'b0, 1'b0, 1'b1);
        expect_all("foul_tick", 4'd3, 4'd1, 4'd2, 4'd0, 2'b01);
        step(8);

        // 4: GO timeout after 20 cycles
        step(12);
        check("go3_entry", 8'(state), 8'd2);
        step(19);
        check("go_at19", 8'(state), 8'd2);
        step(1);
        expect_all("timeout", 4'd3, 4'd1, 4'd2, 4'd0, 2'b00);
        step(8);

        // 5: p0 takes two more rounds and wins
        step(12);
        pulse(1'b0, 1'b1, 1'b0);
        expect_all("p0_r2", 4'd3, 4'd2, 4'd2, 4'd0, 2'b01);
        step(8);
        step(12);
        pulse(1'b0, 1'b1, 1'b0);
        expect_all("p0_r3", 4'd3, 4'd3, 4'd2, 4'd0, 2'b01);
        step(8);
        expect_all("win0", 4'd4, 4'd3, 4'd2, 4'd0, 2'b01);
        pulse(1'b0, 1'b1, 1'b1);
        expect_all("win0_btn", 4'd4, 4'd3, 4'd2, 4'd0, 2'b01);
        step(10);
        check("win0_stay", 8'(state), 8'd4);
        pulse(1'b1, 1'b0, 1'b0);
        expect_all("win_restart", 4'd0, 4'd0, 4'd0, 4'd3, 2'b00);

        // 6: reset mid-COUNT at cnt0=1 with a nonzero score
        pulse(1'b1, 1'b0, 1'b0);
        pulse(1'b0, 1'b1, 1'b0);
        expect_all("pre_rst_foul", 4'd3, 4'd0, 4'd1, 4'd0, 2'b10);
        step(8);
        step(8);
        expect_all("pre_rst", 4'd1, 4'd0, 4'd1, 4'd1, 2'b10);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        expect_all("mid_rst", 4'd0, 4'd0, 4'd0, 4'd3, 2'b00);

        // Tick counter cleared by reset: a fresh countdown runs full length
        pulse(1'b1, 1'b0, 1'b0);
        step(3);
        check("post_rst_cnt3", 8'(cnt0), 8'd3);
        step(1);
        check("post_rst_cnt2", 8'(cnt0), 8'd2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
